opb_err_cnt_bank: RTL and testbench

- Parametrised successor to the single-register simulink2ppc error-count readback.
- Holds C_N_CH independent saturating error counters. Each counter is fed by a per-channel error strobe from the fabric, e.g. loopback/XAUI receive checkers.
- Counters are readable by the PPC over OPB and clearable by OPB write, individually or all at once.
- Sits on the OPB bus beside the other software registers; the user side is synchronous to OPB_Clk, so there are no CDC paths inside.

---
 rtl/opb_err_cnt_bank.sv | 157 +++++++++++++++
 tb/tb_opb_err_cnt_bank.sv | 427 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/opb_err_cnt_bank.sv
`default_nettype none
// ============================================================================
// Module      : opb_err_cnt_bank
// Description : OPB-readable bank of C_N_CH saturating per-channel error
//               counters with per-channel / global clear. Optional atomic
//               snapshot of all counters when ERR_CNT_SNAPSHOT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module opb_err_cnt_bank #(
    parameter logic [31:0] C_BASEADDR   = 32'h01008900,
    parameter logic [31:0] C_HIGHADDR   = 32'h010089FF,
    parameter int          C_OPB_AWIDTH = 32,
    parameter int          C_OPB_DWIDTH = 32,
    parameter int          C_N_CH       = 4,
    parameter int          C_CNT_WIDTH  = 32
) (
    input  logic                      OPB_Clk,
    input  logic                      OPB_Rst,
    input  logic [0:C_OPB_AWIDTH-1]   OPB_ABus,
    input  logic [0:3]                OPB_BE,
    input  logic [0:C_OPB_DWIDTH-1]   OPB_DBus,
    input  logic                      OPB_RNW,
    input  logic                      OPB_select,
    input  logic                      OPB_seqAddr,
    output logic [0:C_OPB_DWIDTH-1]   Sl_DBus,
    output logic                      Sl_xferAck,
    output logic                      Sl_errAck,
    output logic                      Sl_retry,
    output logic                      Sl_toutSup,
    input  logic [C_N_CH-1:0]         user_err_in
);

    localparam int                      c_iw        = C_OPB_AWIDTH - 2;
    localparam logic [C_OPB_AWIDTH-1:0] c_base_addr = C_BASEADDR[C_OPB_AWIDTH-1:0];
    localparam logic [C_OPB_AWIDTH-1:0] c_high_addr = C_HIGHADDR[C_OPB_AWIDTH-1:0];
    localparam logic [c_iw-1:0]         c_ctrl_idx  = c_iw'(C_N_CH);
    localparam logic [C_CNT_WIDTH-1:0]  c_cnt_one   = C_CNT_WIDTH'(1);

    logic [C_OPB_AWIDTH-1:0]        w_addr;
    logic [C_OPB_AWIDTH-1:0]        w_off;
    logic [c_iw-1:0]                w_idx;
    logic [C_OPB_DWIDTH-1:0]        w_wdata;
    logic [C_OPB_DWIDTH-1:0]        w_rdata;
    logic                           w_in_range;
    logic                           w_hit;
    logic                           w_wr;
    logic                           w_is_ctrl;
    logic                           w_clr_all;
    logic [C_N_CH*C_CNT_WIDTH-1:0]  w_cnt_flat;
    logic [C_N_CH*C_CNT_WIDTH-1:0]  w_rd_flat;
    logic [C_N_CH-1:0]              w_sat;
    logic                           w_unused;

    logic                           r_ack;
    logic [C_OPB_DWIDTH-1:0]        r_dbus;

    // Big-endian OPB buses map positionally, so bit 0 of these vectors is the LSB.
    assign w_addr     = OPB_ABus;
    assign w_wdata    = OPB_DBus;
    assign w_off      = w_addr - c_base_addr;
    assign w_idx      = w_off[C_OPB_AWIDTH-1:2];
    assign w_in_range = (w_addr >= c_base_addr) && (w_addr <= c_high_addr);
    assign w_hit      = OPB_select && w_in_range && !r_ack;
    assign w_wr       = w_hit && !OPB_RNW;
    assign w_is_ctrl  = (w_idx == c_ctrl_idx);
    assign w_clr_all  = w_wr && w_is_ctrl && w_wdata[0];

`ifdef ERR_CNT_SNAPSHOT_EN
    logic                           w_snap;
    logic [C_N_CH*C_CNT_WIDTH-1:0]  w_shadow_flat;

    assign w_snap    = w_wr && w_is_ctrl && w_wdata[1];
    assign w_rd_flat = w_shadow_flat;
    assign w_unused  = ^{OPB_BE, OPB_seqAddr, w_wdata[C_OPB_DWIDTH-1:2], w_off[1:0]};
`else
    assign w_rd_flat = w_cnt_flat;
    assign w_unused  = ^{OPB_BE, OPB_seqAddr, w_wdata[C_OPB_DWIDTH-1:1], w_off[1:0]};
`endif

    generate
        for (genvar i = 0; i < C_N_CH; i++) begin : g_ch
            logic                   w_clr;
            logic [C_CNT_WIDTH-1:0] r_cnt;
            logic                   r_sat;

            assign w_clr = w_clr_all || (w_wr && (w_idx == c_iw'(i)));

            // A clear coinciding with a strobe restarts at 1 so the event is kept.
            always_ff @(posedge OPB_Clk) begin
                if (!OPB_Rst) begin
                    r_cnt <= '0;
                    r_sat <= 1'b0;
                end else if (w_clr) begin
                    r_cnt <= user_err_in[i] ? c_cnt_one : '0;
                    r_sat <= 1'b0;
                end else if (user_err_in[i]) begin
                    if (&r_cnt) begin
                        r_sat <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
            end

            assign w_cnt_flat[i*C_CNT_WIDTH +: C_CNT_WIDTH] = r_cnt;
            assign w_sat[i] = r_sat;

`ifdef ERR_CNT_SNAPSHOT_EN
            logic [C_CNT_WIDTH-1:0] r_shadow;

            always_ff @(posedge OPB_Clk) begin
                if (!OPB_Rst) begin
                    r_shadow <= '0;
                end else if (w_snap) begin
                    r_shadow <= r_cnt;
                end
            end

            assign w_shadow_flat[i*C_CNT_WIDTH +: C_CNT_WIDTH] = r_shadow;
`endif
        end
    endgenerate

    always_comb begin
        w_rdata = '0;
        for (int k = 0; k < C_N_CH; k++) begin
            if (w_idx == c_iw'(k)) begin
                w_rdata[C_CNT_WIDTH-1:0] = w_rd_flat[k*C_CNT_WIDTH +: C_CNT_WIDTH];
            end
        end
        if (w_is_ctrl) begin
            w_rdata[C_N_CH-1:0] = w_sat;
            w_rdata[23:16]      = 8'(C_N_CH);
`ifdef ERR_CNT_SNAPSHOT_EN
            w_rdata[24]         = 1'b1;
`endif
        end
    end

    always_ff @(posedge OPB_Clk) begin
        if (!OPB_Rst) begin
            r_ack  <= 1'b0;
            r_dbus <= '0;
        end else begin
            r_ack  <= w_hit;
            r_dbus <= (w_hit && OPB_RNW) ? w_rdata : '0;
        end
    end

    assign Sl_DBus    = r_dbus;
    assign Sl_xferAck = r_ack;
    assign Sl_errAck  = 1'b0;
    assign Sl_retry   = 1'b0;
    assign Sl_toutSup = 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_opb_err_cnt_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_opb_err_cnt_bank
// Description : Self-checking bench for opb_err_cnt_bank (honours ERR_CNT_SNAPSHOT_EN).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_opb_err_cnt_bank;

    localparam int          N    = 4;
    localparam int          CW   = 6;
    localparam int          MAXC = (1 << CW) - 1;
    localparam logic [31:0] BASE = 32'h01008900;
    localparam logic [31:0] HIGH = 32'h010089FF;
    localparam logic [31:0] CTRL = BASE + N * 4;
`ifdef ERR_CNT_SNAPSHOT_EN
    localparam logic [31:0] SNAPBIT = 32'h0100_0000;
`else
    localparam logic [31:0] SNAPBIT = 32'h0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic [0:31]   abus;
    logic [0:3]    be;
    logic [0:31]   dbus;
    logic          rnw;
    logic          sel;
    logic          seqa;
    logic [0:31]   sl_dbus;
    logic          ack;
    logic          erra;
    logic          retry;
    logic          tout;
    logic [N-1:0]  err;

    int            total = 0;
    int            bad   = 0;

    int            m_n[N];
    int            m_sh[N];
    bit            m_ack;
    logic [31:0]   m_rd;
    logic          obs_ack;
    logic [31:0]   obs_dbus;

    always #5 clk = ~clk;

    opb_err_cnt_bank #(
        .C_BASEADDR  (BASE),
        .C_HIGHADDR  (HIGH),
        .C_OPB_AWIDTH(32),
        .C_OPB_DWIDTH(32),
        .C_N_CH      (N),
        .C_CNT_WIDTH (CW)
    ) dut (
        .OPB_Clk    (clk),
        .OPB_Rst    (rst_n),
        .OPB_ABus   (abus),
        .OPB_BE     (be),
        .OPB_DBus   (dbus),
        .OPB_RNW    (rnw),
        .OPB_select (sel),
        .OPB_seqAddr(seqa),
        .Sl_DBus    (sl_dbus),
        .Sl_xferAck (ack),
        .Sl_errAck  (erra),
        .Sl_retry   (retry),
        .Sl_toutSup (tout),
        .user_err_in(err)
    );

    // Reference: each channel is the number of strobes since its last clear;
    // visible count is that number capped at MAXC, sat means it exceeded MAXC.
    function automatic int cap(input int n);
        return (n > MAXC) ? MAXC : n;
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] addr);
        int idx = int'((addr - BASE) >> 2);
        logic [31:0] v = '0;
        if (idx < N) begin
`ifdef ERR_CNT_SNAPSHOT_EN
            v = 32'(m_sh[idx]);
`else
            v = 32'(cap(m_n[idx]));
`endif
        end else if (idx == N) begin
            for (int c = 0; c < N; c++) v[c] = (m_n[c] > MAXC);
            v = v | (32'(N) << 16) | SNAPBIT;
        end
        return v;
    endfunction

    task automatic model_step(input logic [N-1:0] e, input bit wr, input logic [31:0] addr,
                              input logic [31:0] data);
        int idx = int'((addr - BASE) >> 2);
        bit clr;
`ifdef ERR_CNT_SNAPSHOT_EN
        if (wr && idx == N && data[1]) begin
            for (int c = 0; c < N; c++) m_sh[c] = cap(m_n[c]);
        end
`endif
        for (int c = 0; c < N; c++) begin
            clr = wr && (idx == c || (idx == N && data[0]));
            if (clr)                          m_n[c] = e[c] ? 1 : 0;
            else if (e[c] && m_n[c] <= MAXC)  m_n[c] = m_n[c] + 1;
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < N; c++) begin
            m_n[c]  = 0;
            m_sh[c] = 0;
        end
        m_ack = 1'b0;
        m_rd  = '0;
    endtask

    // One bus clock: drive, advance model for the edge, sample 1 ns after it.
    task automatic cycle(input logic [N-1:0] e, input logic s, input logic r,
                         input logic [31:0] addr, input logic [31:0] data);
        bit hit;
        logic [31:0] rd;
        err  = e;
        sel  = s;
        rnw  = r;
        abus = addr;
        dbus = data;
        hit  = s && (addr >= BASE) && (addr <= HIGH) && !m_ack;
        rd   = (hit && r) ? model_read(addr) : 32'h0;
        @(posedge clk);
        model_step(e, hit && !r, addr, data);
        m_ack = hit;
        m_rd  = rd;
        #1;
        obs_ack  = ack;
        obs_dbus = sl_dbus;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle('0, 1'b0, 1'b1, BASE, 32'h0);
    endtask

    task automatic strobe(input logic [N-1:0] e, input int n);
        for (int i = 0; i < n; i++) cycle(e, 1'b0, 1'b1, BASE, 32'h0);
    endtask

    task automatic do_read(input logic [31:0] addr, output logic [31:0] d, output logic a);
        cycle('0, 1'b1, 1'b1, addr, 32'h0);
        d = obs_dbus;
        a = obs_ack;
        idle(1);
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data);
        cycle('0, 1'b1, 1'b0, addr, data);
        idle(1);
    endtask

    // Channel reads come from shadows in snapshot builds; take one first.
    task automatic refresh();
`ifdef ERR_CNT_SNAPSHOT_EN
        do_write(CTRL, 32'h2);
`endif
    endtask

    task automatic test_reset();
        logic [31:0] d;
        logic a;
        rst_n = 1'b0;
        sel   = 1'b1;
        rnw   = 1'b1;
        abus  = BASE;
        dbus  = '0;
        be    = '1;
        seqa  = 1'b0;
        err   = '1;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (ack !== 1'b0 || sl_dbus !== 32'h0) begin
            bad++;
            $display("FAIL reset_hold: ack=%b dbus=%h want ack=0 dbus=0", ack, sl_dbus);
        end
        total++;
        if ({erra, retry, tout} !== 3'b000) begin
            bad++;
            $display("FAIL tieoffs: got %b want 000", {erra, retry, tout});
        end
        rst_n = 1'b1;
        model_reset();
        idle(1);
        total++;
        if (obs_ack !== 1'b0) begin
            bad++;
            $display("FAIL reset_idle_ack: got %b want 0", obs_ack);
        end
        cycle('0, 1'b1, 1'b1, BASE, 32'h0);
        total++;
        if (obs_ack !== 1'b1 || obs_dbus !== 32'h0) begin
            bad++;
            $display("FAIL reset_read0: ack=%b dbus=%h want ack=1 dbus=0", obs_ack, obs_dbus);
        end
        idle(1);
        total++;
        if (obs_ack !== 1'b0) begin
            bad++;
            $display("FAIL reset_ack_single: got %b want 0", obs_ack);
        end
        do_read(CTRL, d, a);
        total++;
        if (a !== 1'b1 || d !== (32'h0004_0000 | SNAPBIT)) begin
            bad++;
            $display("FAIL reset_ctrl: ack=%b got %h want %h", a, d, 32'h0004_0000 | SNAPBIT);
        end
    endtask

    task automatic test_counting();
        logic [31:0] d;
        logic a;
        strobe(4'b0100, 37);
        refresh();
        for (int c = 0; c < N; c++) begin
            cycle('0, 1'b1, 1'b1, BASE + 32'(c * 4), 32'h0);
            d = obs_dbus;
            total++;
            if (d !== ((c == 2) ? 32'd37 : 32'd0) || d !== m_rd) begin
                bad++;
                $display("FAIL count_ch%0d: got %0d want %0d", c, d, (c == 2) ? 37 : 0);
            end
            idle(1);
            total++;
            if (obs_dbus !== 32'h0) begin
                bad++;
                $display("FAIL dbus_idle_ch%0d: got %h want 0", c, obs_dbus);
            end
        end
        do_read(BASE + 32'((N + 2) * 4), d, a);
        total++;
        if (a !== 1'b1 || d !== 32'h0) begin
            bad++;
            $display("FAIL high_index: ack=%b got %h want ack=1 data=0", a, d);
        end
    endtask

    task automatic test_saturation();
        logic [31:0] d;
        logic a;
        do_write(CTRL, 32'h1);
        strobe(4'b0010, MAXC + 17);
        refresh();
        do_read(BASE + 32'h4, d, a);
        total++;
        if (d !== 32'(MAXC)) begin
            bad++;
            $display("FAIL sat_value: got %0d want %0d", d, MAXC);
        end
        do_read(CTRL, d, a);
        total++;
        if (d !== (32'h0004_0002 | SNAPBIT)) begin
            bad++;
            $display("FAIL sat_flag: got %h want %h", d, 32'h0004_0002 | SNAPBIT);
        end
        do_write(BASE + 32'h4, $urandom);
        refresh();
        do_read(BASE + 32'h4, d, a);
        total++;
        if (d !== 32'h0) begin
            bad++;
            $display("FAIL sat_clear_cnt: got %0d want 0", d);
        end
        do_read(CTRL, d, a);
        total++;
        if (d !== (32'h0004_0000 | SNAPBIT)) begin
            bad++;
            $display("FAIL sat_clear_flag: got %h want %h", d, 32'h0004_0000 | SNAPBIT);
        end
    endtask

    task automatic test_collision();
        logic [31:0] d;
        logic a;
        do_write(CTRL, 32'h1);
        strobe(4'b0001, 9);
        refresh();
        do_read(BASE, d, a);
        total++;
        if (d !== 32'd9) begin
            bad++;
            $display("FAIL coll_pre: got %0d want 9", d);
        end
        cycle(4'b0001, 1'b1, 1'b0, BASE, $urandom);
        idle(1);
        refresh();
        do_read(BASE, d, a);
        total++;
        if (d !== 32'd1) begin
            bad++;
            $display("FAIL coll_chan: got %0d want 1", d);
        end
        strobe(4'b0001, 4);
        cycle(4'b0001, 1'b1, 1'b0, CTRL, 32'h1);
        idle(1);
        refresh();
        do_read(BASE, d, a);
        total++;
        if (d !== 32'd1) begin
            bad++;
            $display("FAIL coll_all: got %0d want 1", d);
        end
    endtask

    task automatic test_handshake();
        logic [5:0] pat;
        idle(2);
        for (int i = 0; i < 6; i++) begin
            cycle('0, 1'b1, 1'b1, BASE + 32'h4, 32'h0);
            pat[i] = obs_ack;
            total++;
            if (obs_dbus !== (obs_ack ? m_rd : 32'h0)) begin
                bad++;
                $display("FAIL hs_dbus%0d: got %h want %h", i, obs_dbus, obs_ack ? m_rd : 32'h0);
            end
        end
        total++;
        if (pat !== 6'b010101) begin
            bad++;
            $display("FAIL hs_pattern: got %b want 010101 (bit0 first)", pat);
        end
        idle(1);
        for (int i = 0; i < 3; i++) begin
            cycle('0, 1'b1, 1'b1, HIGH + 32'h4, 32'h0);
            total++;
            if (obs_ack !== 1'b0) begin
                bad++;
                $display("FAIL hs_out_of_range%0d: got %b want 0", i, obs_ack);
            end
        end
        idle(1);
    endtask

    task automatic test_back_to_back();
        logic [2:0] pat;
        strobe(4'b1000, 5);
        cycle('0, 1'b1, 1'b0, CTRL, 32'h1);
        pat[0] = obs_ack;
        cycle('0, 1'b1, 1'b1, BASE + 32'hC, 32'h0);
        pat[1] = obs_ack;
        cycle('0, 1'b1, 1'b1, BASE + 32'hC, 32'h0);
        pat[2] = obs_ack;
        total++;
        if (pat !== 3'b101 || obs_dbus !== m_rd) begin
            bad++;
            $display("FAIL b2b: ack pattern %b data %h want 101 data %h", pat, obs_dbus, m_rd);
        end
        idle(1);
    endtask

    task automatic test_random();
        logic [31:0] addr;
        int r;
        for (int i = 0; i < 400; i++) begin
            r = int'($urandom_range(0, 15));
            if (r == 0)      addr = HIGH + 32'h4;
            else if (r == 1) addr = BASE - 32'h4;
            else             addr = BASE + 32'($urandom_range(0, N + 3) * 4);
            cycle(N'($urandom), ($urandom_range(0, 2) != 0), $urandom_range(0, 3) != 0,
                  addr, (r == 2) ? $urandom : ($urandom & 32'hFFFF_FFFE));
            total++;
            if (obs_ack !== m_ack || obs_dbus !== m_rd) begin
                bad++;
                $display("FAIL rand%0d: ack=%b dbus=%h want ack=%b dbus=%h",
                         i, obs_ack, obs_dbus, m_ack, m_rd);
            end
        end
        idle(1);
    endtask

`ifdef ERR_CNT_SNAPSHOT_EN
    task automatic test_snapshot();
        logic [31:0] d;
        logic a;
        do_write(CTRL, 32'h1);
        strobe(4'b0001, 10);
        do_write(CTRL, 32'h2);
        strobe(4'b0001, 5);
        do_read(BASE, d, a);
        total++;
        if (d !== 32'd10) begin
            bad++;
            $display("FAIL snap_first: got %0d want 10", d);
        end
        do_read(CTRL, d, a);
        total++;
        if (d[24] !== 1'b1) begin
            bad++;
            $display("FAIL snap_mode_bit: got %b want 1", d[24]);
        end
        do_write(CTRL, 32'h2);
        do_write(CTRL, 32'h1);
        do_read(BASE, d, a);
        total++;
        if (d !== 32'd15) begin
            bad++;
            $display("FAIL snap_second: got %0d want 15", d);
        end
    endtask
`endif

    initial begin
        model_reset();
        test_reset();
        test_counting();
        test_saturation();
        test_collision();
        test_handshake();
        test_back_to_back();
`ifdef ERR_CNT_SNAPSHOT_EN
        test_snapshot();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
